// File: rtl/s_axis_rq_arbiter_x4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | s_axis_rq_arbiter_x4_pkg : shared types for the RQ stream arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package s_axis_rq_arbiter_x4_pkg;

  localparam int RQ_USER_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_pipe_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_pipe_reg : one-entry registered AXI-Stream output stage      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axis_pipe_reg #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_last,
  input  logic [USER_WIDTH-1:0] i_user,
  input  logic                  i_ready,
  output logic                  o_can_load,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [KEEP_WIDTH-1:0] o_keep,
  output logic                  o_last,
  output logic [USER_WIDTH-1:0] o_user
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  // Space is available when empty or when the held beat leaves this cycle.
  assign o_can_load = ~r_valid | i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_user  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
      r_user  <= i_user;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;
  assign o_user  = r_user;

endmodule
`default_nettype wire

// File: rtl/s_axis_rq_arbiter_x4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | s_axis_rq_arbiter_x4 : packet round-robin of two RQ requesters    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module s_axis_rq_arbiter_x4
  import s_axis_rq_arbiter_x4_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,
  input  logic [DATA_WIDTH-1:0]    s0_tdata,
  input  logic [KEEP_WIDTH-1:0]    s0_tkeep,
  input  logic                     s0_tlast,
  input  logic [RQ_USER_WIDTH-1:0] s0_tuser,
  input  logic                     s0_tvalid,
  output logic                     s0_tready,
  input  logic [DATA_WIDTH-1:0]    s1_tdata,
  input  logic [KEEP_WIDTH-1:0]    s1_tkeep,
  input  logic                     s1_tlast,
  input  logic [RQ_USER_WIDTH-1:0] s1_tuser,
  input  logic                     s1_tvalid,
  output logic                     s1_tready,
  output logic [DATA_WIDTH-1:0]    s_axis_rq_tdata_a,
  output logic [KEEP_WIDTH-1:0]    s_axis_rq_tkeep_a,
  output logic                     s_axis_rq_tlast_a,
  output logic [RQ_USER_WIDTH-1:0] s_axis_rq_tuser_a,
  output logic                     s_axis_rq_tvalid_a,
  input  logic [3:0]               s_axis_rq_tready_a,
  output logic [15:0]              pkt_count0,
  output logic [15:0]              pkt_count1
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   r_last_grant;
  logic   w_win;
  logic   w_arb;

  logic [15:0] r_pkt_count0;
  logic [15:0] r_pkt_count1;

  logic                     w_lock;
  logic                     w_can_load;
  logic                     w_load;
  logic                     w_g_ready;
  logic                     w_pkt_end;
  logic                     w_g_valid;
  logic [DATA_WIDTH-1:0]    w_g_data;
  logic [KEEP_WIDTH-1:0]    w_g_keep;
  logic                     w_g_last;
  logic [RQ_USER_WIDTH-1:0] w_g_user;
  logic                     w_unused_ready;

  assign w_unused_ready = &{1'b0, s_axis_rq_tready_a[3:1]};

  assign w_g_valid = r_grant ? s1_tvalid : s0_tvalid;
  assign w_g_data  = r_grant ? s1_tdata  : s0_tdata;
  assign w_g_keep  = r_grant ? s1_tkeep  : s0_tkeep;
  assign w_g_last  = r_grant ? s1_tlast  : s0_tlast;
  assign w_g_user  = r_grant ? s1_tuser  : s0_tuser;

  assign w_lock    = (r_state == LOCK);
  assign w_g_ready = w_lock & w_can_load;
  assign w_load    = w_g_ready & w_g_valid;
  assign w_pkt_end = w_load & w_g_last;

  assign s0_tready = w_g_ready & ~r_grant;
  assign s1_tready = w_g_ready &  r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_win       = r_grant;
    w_arb       = 1'b0;
    case (r_state)
      IDLE: begin
        if (s0_tvalid | s1_tvalid) begin
          w_arb       = 1'b1;
          w_state_nxt = LOCK;
          // On a tie the port that did not win last time goes next.
          w_win       = (s0_tvalid & s1_tvalid) ? ~r_last_grant : s1_tvalid;
        end
      end
      LOCK: begin
        if (w_pkt_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_pkt_count0 <= '0;
      r_pkt_count1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
      if (w_pkt_end) begin
        if (r_grant) begin
          r_pkt_count1 <= r_pkt_count1 + 16'd1;
        end else begin
          r_pkt_count0 <= r_pkt_count0 + 16'd1;
        end
      end
    end
  end

  assign pkt_count0 = r_pkt_count0;
  assign pkt_count1 = r_pkt_count1;

  axis_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (RQ_USER_WIDTH)
  ) u_out_reg (
    .clk        (user_clk),
    .rst_n      (user_reset_n),
    .i_load     (w_load),
    .i_data     (w_g_data),
    .i_keep     (w_g_keep),
    .i_last     (w_g_last),
    .i_user     (w_g_user),
    .i_ready    (s_axis_rq_tready_a[0]),
    .o_can_load (w_can_load),
    .o_valid    (s_axis_rq_tvalid_a),
    .o_data     (s_axis_rq_tdata_a),
    .o_keep     (s_axis_rq_tkeep_a),
    .o_last     (s_axis_rq_tlast_a),
    .o_user     (s_axis_rq_tuser_a)
  );

endmodule
`default_nettype wire

// File: tb/tb_s_axis_rq_arbiter_x4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_s_axis_rq_arbiter_x4 : randomized bench with reference model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_s_axis_rq_arbiter_x4;

  localparam int DW = 128;
  localparam int KW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [3:0]    u;
  } beat_t;

  logic          user_clk = 1'b0;
  logic          user_reset_n = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic [3:0]    s0_tuser = '0, s1_tuser = '0;
  logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] s_axis_rq_tdata_a;
  logic [KW-1:0] s_axis_rq_tkeep_a;
  logic          s_axis_rq_tlast_a;
  logic [3:0]    s_axis_rq_tuser_a;
  logic          s_axis_rq_tvalid_a;
  logic [3:0]    s_axis_rq_tready_a = 4'hF;
  logic [15:0]   pkt_count0, pkt_count1;

  always #5 user_clk = ~user_clk;

  s_axis_rq_arbiter_x4 #(.DATA_WIDTH(DW)) dut (
    .user_clk           (user_clk),
    .user_reset_n       (user_reset_n),
    .s0_tdata           (s0_tdata),
    .s0_tkeep           (s0_tkeep),
    .s0_tlast           (s0_tlast),
    .s0_tuser           (s0_tuser),
    .s0_tvalid          (s0_tvalid),
    .s0_tready          (s0_tready),
    .s1_tdata           (s1_tdata),
    .s1_tkeep           (s1_tkeep),
    .s1_tlast           (s1_tlast),
    .s1_tuser           (s1_tuser),
    .s1_tvalid          (s1_tvalid),
    .s1_tready          (s1_tready),
    .s_axis_rq_tdata_a  (s_axis_rq_tdata_a),
    .s_axis_rq_tkeep_a  (s_axis_rq_tkeep_a),
    .s_axis_rq_tlast_a  (s_axis_rq_tlast_a),
    .s_axis_rq_tuser_a  (s_axis_rq_tuser_a),
    .s_axis_rq_tvalid_a (s_axis_rq_tvalid_a),
    .s_axis_rq_tready_a (s_axis_rq_tready_a),
    .pkt_count0         (pkt_count0),
    .pkt_count1         (pkt_count1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the stream.
  int          m_owner;
  int          m_lastg;
  bit          m_ov;
  beat_t       m_out;
  logic [15:0] m_cnt0, m_cnt1;
  bit          acc0, acc1;

  beat_t         q0[$], q1[$];
  logic [3:0]    rdy_script[$];
  logic [DW-1:0] out_log[$];
  logic          last_log[$];
  int            valid_pct = 100;
  bit            auto_gen = 0;
  int            rdy_mode = 0;
  int            acc_count0 = 0;
  logic [15:0]   gen_cnt0 = 0, gen_cnt1 = 0;

  function automatic beat_t rand_beat();
    beat_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom};
    b.k = 16'($urandom);
    b.l = 1'($urandom);
    b.u = 4'($urandom);
    return b;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_lastg = 1; m_ov = 0; m_out = '0;
    m_cnt0 = 0; m_cnt1 = 0; acc0 = 0; acc1 = 0;
  endtask

  task automatic push_beat(input int p, input logic [DW-1:0] d, input bit last);
    beat_t b;
    b = rand_beat();
    b.d = d;
    b.l = last;
    if (p == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic push_pkt(input int p, input int len, input logic [7:0] base);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[127:120] = 8'(p);
      d[7:0] = base + 8'(i);
      push_beat(p, d, i == len - 1);
    end
  endtask

  task automatic put(input int p, input beat_t b, input bit v);
    if (p == 0) begin
      s0_tdata = b.d; s0_tkeep = b.k; s0_tlast = b.l; s0_tuser = b.u; s0_tvalid = v;
    end else begin
      s1_tdata = b.d; s1_tkeep = b.k; s1_tlast = b.l; s1_tuser = b.u; s1_tvalid = v;
    end
  endtask

  task automatic drive_update();
    bit    held;
    int    qs;
    beat_t b;
    for (int p = 0; p < 2; p++) begin
      if (p == 0 && acc0) s0_tvalid = 1'b0;
      if (p == 1 && acc1) s1_tvalid = 1'b0;
      held = (p == 0) ? s0_tvalid : s1_tvalid;
      if (!held) begin
        qs = (p == 0) ? q0.size() : q1.size();
        if (auto_gen && qs == 0 && $urandom_range(0, 99) < 30) begin
          push_pkt(p, $urandom_range(1, 4), 8'($urandom));
          if (p == 0) gen_cnt0++; else gen_cnt1++;
          qs = 1;
        end
        if (qs > 0 && $urandom_range(0, 99) < valid_pct) begin
          b = (p == 0) ? q0.pop_front() : q1.pop_front();
          put(p, b, 1'b1);
        end else begin
          put(p, rand_beat(), 1'b0);
        end
      end
    end
    if (rdy_script.size() > 0) s_axis_rq_tready_a = rdy_script.pop_front();
    else if (rdy_mode == 0)    s_axis_rq_tready_a = 4'hF;
    else s_axis_rq_tready_a = {3'($urandom), ($urandom_range(0, 99) < 75)};
  endtask

  task automatic step();
    bit    cn, e0, e1;
    int    w;
    beat_t b0, b1;
    #1;
    cn = !m_ov || s_axis_rq_tready_a[0];
    e0 = (m_owner == 0) && cn;
    e1 = (m_owner == 1) && cn;
    chk("s0_tready", DW'(s0_tready), DW'(e0));
    chk("s1_tready", DW'(s1_tready), DW'(e1));
    chk("tvalid_a", DW'(s_axis_rq_tvalid_a), DW'(m_ov));
    if (m_ov) begin
      chk("tdata_a", s_axis_rq_tdata_a, m_out.d);
      chk("tkeep_a", DW'(s_axis_rq_tkeep_a), DW'(m_out.k));
      chk("tlast_a", DW'(s_axis_rq_tlast_a), DW'(m_out.l));
      chk("tuser_a", DW'(s_axis_rq_tuser_a), DW'(m_out.u));
    end
    chk("pkt_count0", DW'(pkt_count0), DW'(m_cnt0));
    chk("pkt_count1", DW'(pkt_count1), DW'(m_cnt1));
    if (s_axis_rq_tvalid_a && s_axis_rq_tready_a[0]) begin
      out_log.push_back(s_axis_rq_tdata_a);
      last_log.push_back(s_axis_rq_tlast_a);
    end
    b0 = {s0_tdata, s0_tkeep, s0_tlast, s0_tuser};
    b1 = {s1_tdata, s1_tkeep, s1_tlast, s1_tuser};
    acc0 = e0 && s0_tvalid;
    acc1 = e1 && s1_tvalid;
    if (acc0) acc_count0++;
    if (m_owner < 0) begin
      if (s_axis_rq_tready_a[0]) m_ov = 0;
      if (s0_tvalid || s1_tvalid) begin
        w = (s0_tvalid && s1_tvalid) ? 1 - m_lastg : (s1_tvalid ? 1 : 0);
        m_owner = w;
        m_lastg = w;
      end
    end else if (acc0 || acc1) begin
      m_out = acc0 ? b0 : b1;
      m_ov  = 1;
      if (m_out.l) begin
        if (m_owner == 0) m_cnt0++; else m_cnt1++;
        m_owner = -1;
      end
    end else if (s_axis_rq_tready_a[0]) begin
      m_ov = 0;
    end
    @(posedge user_clk);
    #1;
    drive_update();
    @(negedge user_clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_stim();
    q0.delete(); q1.delete(); rdy_script.delete();
    put(0, rand_beat(), 1'b0);
    put(1, rand_beat(), 1'b0);
    s_axis_rq_tready_a = 4'hF;
  endtask

  task automatic do_reset();
    user_reset_n = 1'b0;
    clear_stim();
    model_reset();
    repeat (2) @(negedge user_clk);
    user_reset_n = 1'b1;
    out_log.delete(); last_log.delete();
  endtask

  initial begin
    int guard;
    // Reset state
    model_reset();
    clear_stim();
    #12;
    chk("rst_tvalid_a", DW'(s_axis_rq_tvalid_a), '0);
    chk("rst_tdata_a", s_axis_rq_tdata_a, '0);
    chk("rst_tready", DW'({s0_tready, s1_tready}), '0);
    chk("rst_counts", DW'({pkt_count0, pkt_count1}), '0);
    @(negedge user_clk);
    do_reset();

    // Single port, three beats
    valid_pct = 100; rdy_mode = 0;
    push_beat(0, 128'h11, 1'b0);
    push_beat(0, 128'h22, 1'b0);
    push_beat(0, 128'h33, 1'b1);
    drive_update();
    run(10);
    chk("single_len", DW'(out_log.size()), DW'(3));
    if (out_log.size() == 3) begin
      chk("single_b0", out_log[0], 128'h11);
      chk("single_b1", out_log[1], 128'h22);
      chk("single_b2", out_log[2], 128'h33);
      chk("single_last", DW'({last_log[0], last_log[1], last_log[2]}), DW'(3'b001));
    end
    chk("single_cnt0", DW'(pkt_count0), DW'(1));

    // Tie from reset: alternating 2-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 2, 8'(i * 2));
      push_pkt(1, 2, 8'(i * 2));
    end
    drive_update();
    run(40);
    chk("tie_len", DW'(out_log.size()), DW'(16));
    for (int i = 0; i < out_log.size() && i < 16; i++)
      chk("tie_order", DW'(out_log[i][127:120]), DW'((i / 2) % 2));
    chk("tie_cnt0", DW'(pkt_count0), DW'(4));
    chk("tie_cnt1", DW'(pkt_count1), DW'(4));

    // Lock: s1 held valid while s0 streams 8 beats
    out_log.delete(); last_log.delete();
    push_pkt(0, 8, 8'h40);
    push_pkt(1, 2, 8'h50);
    drive_update();
    run(20);
    chk("lock_len", DW'(out_log.size()), DW'(10));
    for (int i = 0; i < out_log.size() && i < 10; i++)
      chk("lock_order", DW'(out_log[i][127:120]), DW'(i >= 8));

    // Backpressure mid-packet, upper tready bits toggling
    out_log.delete(); last_log.delete();
    push_pkt(0, 4, 8'hB0);
    rdy_script = '{4'hF, 4'hF, 4'hF, 4'h1, 4'hE, 4'h0, 4'hF, 4'h3, 4'hC};
    drive_update();
    run(14);
    chk("bp_len", DW'(out_log.size()), DW'(4));
    for (int i = 0; i < out_log.size() && i < 4; i++)
      chk("bp_data", DW'(out_log[i][7:0]), DW'(8'hB0 + 8'(i)));

    // Reset on beat 2 of 4
    push_pkt(0, 4, 8'hC0);
    acc_count0 = 0;
    drive_update();
    guard = 0;
    while (acc_count0 < 2 && guard < 30) begin
      step();
      guard++;
    end
    chk("rst_mid_reached", DW'(acc_count0 >= 2), DW'(1));
    #2;
    user_reset_n = 1'b0;
    #1;
    chk("rst_mid_tvalid_a", DW'(s_axis_rq_tvalid_a), '0);
    chk("rst_mid_tready", DW'({s0_tready, s1_tready}), '0);
    chk("rst_mid_counts", DW'({pkt_count0, pkt_count1}), '0);
    @(negedge user_clk);
    do_reset();
    push_pkt(0, 1, 8'hD0);
    push_pkt(1, 1, 8'hD1);
    drive_update();
    run(8);
    chk("rst_tie_len", DW'(out_log.size()), DW'(2));
    if (out_log.size() > 0) chk("rst_tie_first", DW'(out_log[0][127:120]), DW'(0));

    // Counter wrap on port 1
    force dut.r_pkt_count1 = 16'hFFFF;
    @(posedge user_clk);
    #1;
    release dut.r_pkt_count1;
    @(negedge user_clk);
    m_cnt1 = 16'hFFFF;
    push_pkt(1, 1, 8'hE0);
    drive_update();
    run(6);
    chk("wrap_cnt1", DW'(pkt_count1), DW'(0));

    // Randomized traffic
    do_reset();
    gen_cnt0 = 0; gen_cnt1 = 0;
    auto_gen = 1; valid_pct = 70; rdy_mode = 1;
    drive_update();
    run(3000);
    auto_gen = 0; valid_pct = 100; rdy_mode = 0;
    run(80);
    chk("rand_cnt0", DW'(pkt_count0), DW'(gen_cnt0));
    chk("rand_cnt1", DW'(pkt_count1), DW'(gen_cnt1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
